// File: rtl/pacman_pkg.sv
// Shared types and constants for the PacMan game-flow logic.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DYING = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  localparam int POS_W_DEF = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_divider.sv
// Divides frame_tick by PERIOD and emits a registered one-cycle step pulse.
// The count only advances while en is high and can be cleared with clr.
module frame_divider #(
  parameter int PERIOD = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic frame_tick,
  output logic step
);

  localparam int CNT_W = $clog2(PERIOD) + 1;

  logic [CNT_W-1:0] cnt;

  // Count enabled ticks; pulse step the cycle after the PERIOD-th one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (en && frame_tick) begin
        if (cnt == CNT_W'(PERIOD - 1)) begin
          cnt  <= '0;
          step <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: start/pause, frame-synchronous move enables,
// pac/ghost collision detection, lives and respawn/game-over sequencing.
// All state lives on CLOCK_50; state_dbg exposes the FSM state.
module game_sequencer
  import pacman_pkg::*;
#(
  parameter int POS_W        = POS_W_DEF,
  parameter int LIVES        = 3,
  parameter int PAC_PERIOD   = 6,
  parameter int GHOST_PERIOD = 12,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 90
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic             frame_tick,
  input  logic [POS_W-1:0] pac_x,
  input  logic [POS_W-1:0] pac_y,
  input  logic [POS_W-1:0] ghost_x,
  input  logic [POS_W-1:0] ghost_y,
  output logic             pac_step,
  output logic             ghost_step,
  output logic             respawn,
  output logic             playing,
  output logic             gameover,
  output logic [1:0]       lives,
  output game_state_t      state_dbg
);

  localparam int FRAME_W = $clog2(max_int(READY_FRAMES, DEATH_FRAMES)) + 1;

  game_state_t      state, next_state;
  logic             start_q, start_edge;
  logic [FRAME_W-1:0] frame_cnt;
  logic [POS_W-1:0] prev_pac_x, prev_pac_y, prev_ghost_x, prev_ghost_y;
  logic             same, swap, coll;
  logic             div_en, div_clr;
  logic             pac_pulse, ghost_pulse;

  // Register start; resets high so a button held through reset is no edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= start;
  end

  // Edge detect and collision: same tile, or pac and ghost swapped tiles.
  always_comb begin
    start_edge = start & ~start_q;
    same = (pac_x == ghost_x) && (pac_y == ghost_y);
    swap = (pac_x == prev_ghost_x) && (pac_y == prev_ghost_y) &&
           (ghost_x == prev_pac_x) && (ghost_y == prev_pac_y) &&
           ((pac_x != prev_pac_x) || (pac_y != prev_pac_y));
    coll = (state == PLAY) && (same || swap);
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic; collision wins over start_edge in PLAY.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_edge) next_state = READY;
      READY: if (frame_tick && frame_cnt == FRAME_W'(READY_FRAMES - 1))
               next_state = PLAY;
      PLAY: begin
        if (coll)            next_state = DYING;
        else if (start_edge) next_state = PAUSE;
      end
      PAUSE: if (start_edge) next_state = PLAY;
      DYING: if (frame_tick && frame_cnt == FRAME_W'(DEATH_FRAMES - 1))
               next_state = (lives == 2'd0) ? OVER : READY;
      OVER:  if (start_edge) next_state = READY;
      default: next_state = IDLE;
    endcase
  end

  // Frame counter for READY/DYING, lives, respawn pulse and previous positions.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frame_cnt    <= '0;
      lives        <= 2'(LIVES);
      respawn      <= 1'b0;
      prev_pac_x   <= '0;
      prev_pac_y   <= '0;
      prev_ghost_x <= '0;
      prev_ghost_y <= '0;
    end else begin
      if (state != next_state)
        frame_cnt <= '0;
      else if ((state == READY || state == DYING) && frame_tick)
        frame_cnt <= frame_cnt + FRAME_W'(1);

      if ((state == IDLE || state == OVER) && next_state == READY)
        lives <= 2'(LIVES);
      else if (state == PLAY && next_state == DYING && lives != 2'd0)
        lives <= lives - 2'd1;

      respawn <= (next_state == READY) && (state != READY);

      if (state == PLAY) begin
        prev_pac_x   <= pac_x;
        prev_pac_y   <= pac_y;
        prev_ghost_x <= ghost_x;
        prev_ghost_y <= ghost_y;
      end
    end
  end

  assign div_en  = (state == PLAY) && !coll;
  assign div_clr = (state == READY) && (next_state == PLAY);

  frame_divider #(.PERIOD(PAC_PERIOD)) u_pac_div (
    .clk        (CLOCK_50),
    .rst        (reset),
    .en         (div_en),
    .clr        (div_clr),
    .frame_tick (frame_tick),
    .step       (pac_pulse)
  );

  frame_divider #(.PERIOD(GHOST_PERIOD)) u_ghost_div (
    .clk        (CLOCK_50),
    .rst        (reset),
    .en         (div_en),
    .clr        (div_clr),
    .frame_tick (frame_tick),
    .step       (ghost_pulse)
  );

  // Outputs decoded from state; steps are only passed through while in PLAY.
  always_comb begin
    playing    = (state == PLAY);
    gameover   = (state == OVER);
    pac_step   = pac_pulse & (state == PLAY);
    ghost_step = ghost_pulse & (state == PLAY);
    state_dbg  = state;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with hand-computed expectations.
module tb_game_sequencer;
  import pacman_pkg::*;

  localparam int POS_W = 5;

  logic             CLOCK_50;
  logic             reset;
  logic             start;
  logic             frame_tick;
  logic [POS_W-1:0] pac_x, pac_y, ghost_x, ghost_y;
  logic             pac_step, ghost_step, respawn, playing, gameover;
  logic [1:0]       lives;
  game_state_t      state_dbg;

  int vectors;
  int miscompares;
  int pac_pulses;
  int ghost_pulses;

  game_sequencer #(
    .POS_W        (POS_W),
    .LIVES        (2),
    .PAC_PERIOD   (2),
    .GHOST_PERIOD (4),
    .READY_FRAMES (3),
    .DEATH_FRAMES (4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .pac_x      (pac_x),
    .pac_y      (pac_y),
    .ghost_x    (ghost_x),
    .ghost_y    (ghost_y),
    .pac_step   (pac_step),
    .ghost_step (ghost_step),
    .respawn    (respawn),
    .playing    (playing),
    .gameover   (gameover),
    .lives      (lives),
    .state_dbg  (state_dbg)
  );

  // Clock and reset-free clock generation (10 ns period).
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
  endtask

  task automatic set_pos(input int px, input int py, input int gx, input int gy);
    pac_x   = POS_W'(px);
    pac_y   = POS_W'(py);
    ghost_x = POS_W'(gx);
    ghost_y = POS_W'(gy);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    pac_pulses   = 0;
    ghost_pulses = 0;
    reset        = 1'b1;
    start        = 1'b1;
    frame_tick   = 1'b0;
    set_pos(1, 1, 10, 10);

    // 1. Reset with start held, then a genuine start edge.
    clk1(); clk1();
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_lives", 32'(lives), 32'd2);
    chk("rst_outs", {27'd0, pac_step, ghost_step, respawn, playing, gameover}, 32'd0);
    reset = 1'b0;
    clk1(); clk1();
    chk("held_start_idle", 32'(state_dbg), 32'(IDLE));
    chk("held_start_no_respawn", 32'(respawn), 32'd0);
    start = 1'b0;
    clk1();
    chk("still_idle", 32'(state_dbg), 32'(IDLE));
    start = 1'b1;
    clk1();
    chk("start_ready", 32'(state_dbg), 32'(READY));
    chk("start_respawn", 32'(respawn), 32'd1);
    chk("start_lives", 32'(lives), 32'd2);
    start = 1'b0;
    clk1();
    chk("respawn_one_cycle", 32'(respawn), 32'd0);

    // 2. READY for 3 ticks, then 8 PLAY ticks: pac every 2nd, ghost every 4th.
    tick(); tick();
    chk("ready_after_2", 32'(state_dbg), 32'(READY));
    tick();
    chk("play_after_3", 32'(playing), 32'd1);
    chk("no_step_on_entry", {30'd0, pac_step, ghost_step}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pac_step_tick", 32'(pac_step), 32'(i % 2 == 1));
      chk("ghost_step_tick", 32'(ghost_step), 32'(i % 4 == 3));
      if (pac_step)   pac_pulses++;
      if (ghost_step) ghost_pulses++;
      clk1();
      chk("steps_one_wide", {30'd0, pac_step, ghost_step}, 32'd0);
    end
    chk("pac_pulse_count", 32'(pac_pulses), 32'd4);
    chk("ghost_pulse_count", 32'(ghost_pulses), 32'd2);

    // 3. Same-tile collision on a tick that would have fired pac_step.
    tick();
    chk("pac_cnt_mid", 32'(pac_step), 32'd0);
    set_pos(3, 4, 3, 4);
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
    chk("coll_dying", 32'(state_dbg), 32'(DYING));
    chk("coll_lives", 32'(lives), 32'd1);
    chk("coll_steps_suppressed", {30'd0, pac_step, ghost_step}, 32'd0);
    chk("coll_not_playing", 32'(playing), 32'd0);
    set_pos(5, 5, 6, 5);
    tick(); tick(); tick();
    chk("dying_after_3", 32'(state_dbg), 32'(DYING));
    tick();
    chk("death_ready", 32'(state_dbg), 32'(READY));
    chk("death_respawn", 32'(respawn), 32'd1);
    clk1();
    chk("death_respawn_off", 32'(respawn), 32'd0);

    // 4. Swap collision: pac and ghost exchange tiles in one cycle.
    tick(); tick(); tick();
    chk("swap_play", 32'(state_dbg), 32'(PLAY));
    clk1();
    chk("swap_prev_no_coll", 32'(state_dbg), 32'(PLAY));
    set_pos(6, 5, 5, 5);
    clk1();
    chk("swap_dying", 32'(state_dbg), 32'(DYING));
    chk("swap_lives", 32'(lives), 32'd0);

    // 5. Last life gone: OVER without respawn, then restart.
    set_pos(1, 1, 10, 10);
    tick(); tick(); tick(); tick();
    chk("over_state", 32'(state_dbg), 32'(OVER));
    chk("over_gameover", 32'(gameover), 32'd1);
    chk("over_no_respawn", 32'(respawn), 32'd0);
    chk("over_lives", 32'(lives), 32'd0);
    start = 1'b1;
    clk1();
    chk("restart_ready", 32'(state_dbg), 32'(READY));
    chk("restart_respawn", 32'(respawn), 32'd1);
    chk("restart_lives", 32'(lives), 32'd2);
    chk("restart_gameover", 32'(gameover), 32'd0);
    start = 1'b0;
    clk1();

    // 6. Pause holds counters and ignores collisions.
    tick(); tick(); tick();
    chk("p6_play", 32'(playing), 32'd1);
    tick();
    chk("p6_first_tick", {30'd0, pac_step, ghost_step}, 32'd0);
    start = 1'b1;
    clk1();
    start = 1'b0;
    chk("pause_state", 32'(state_dbg), 32'(PAUSE));
    chk("pause_not_playing", 32'(playing), 32'd0);
    tick();
    chk("pause_no_steps", {30'd0, pac_step, ghost_step}, 32'd0);
    clk1();
    set_pos(7, 7, 7, 7);
    clk1();
    chk("pause_coll_ignored", 32'(state_dbg), 32'(PAUSE));
    chk("pause_lives_kept", 32'(lives), 32'd2);
    set_pos(1, 1, 10, 10);
    start = 1'b1;
    clk1();
    start = 1'b0;
    chk("resume_play", 32'(state_dbg), 32'(PLAY));
    tick();
    chk("resume_pac_step", 32'(pac_step), 32'd1);
    chk("resume_ghost_quiet", 32'(ghost_step), 32'd0);
    clk1();
    tick();
    chk("resume_2nd", {30'd0, pac_step, ghost_step}, 32'd0);
    clk1();
    tick();
    chk("resume_both", {30'd0, pac_step, ghost_step}, 32'd3);
    clk1();

    // Asynchronous reset in the middle of DYING.
    set_pos(2, 2, 2, 2);
    clk1();
    chk("r_dying", 32'(state_dbg), 32'(DYING));
    chk("r_dying_lives", 32'(lives), 32'd1);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state_dbg), 32'(IDLE));
    chk("async_lives", 32'(lives), 32'd2);
    chk("async_outs", {27'd0, pac_step, ghost_step, respawn, playing, gameover}, 32'd0);
    clk1();
    reset = 1'b0;
    clk1();
    chk("after_reset_idle", 32'(state_dbg), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
